// File: rtl/elevator_pkg.sv
// Shared types for the elevator request scheduler.
// State encoding, default geometry and the floor index type.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 10;
  localparam int DEF_FLOOR_W    = 4;

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SERVE_UP,
    ST_SERVE_DOWN,
    ST_DWELL
  } sched_st_e;

endpackage

// File: rtl/elevator_next_floor_pick.sv
// Nearest pending call at or above / at or below the car.
// Purely combinational priority scans over the pending bitmap.
module elevator_next_floor_pick
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    car_floor,
  output logic [FLOOR_W-1:0]    up_hit,
  output logic                  up_vld,
  output logic [FLOOR_W-1:0]    dn_hit,
  output logic                  dn_vld
);

  // Descending scan: the last match written is the lowest floor.
  always_comb begin
    up_hit = '0;
    up_vld = 1'b0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) >= car_floor)) begin
        up_hit = FLOOR_W'(f);
        up_vld = 1'b1;
      end
    end
  end

  always_comb begin
    dn_hit = '0;
    dn_vld = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) <= car_floor)) begin
        dn_hit = FLOOR_W'(f);
        dn_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK scheduler: call bitmap, travel FSM and door dwell timer.
// SCHED_SERVED_CNT_EN builds the served-stop counter.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int FLOOR_W      = DEF_FLOOR_W,
  parameter int DWELL_CYCLES = 20000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  req_err,
  output logic [15:0]           served_cnt
);

  localparam int CNT_W =
    (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD =
    CNT_W'(DWELL_CYCLES - 1);
  localparam int RW = FLOOR_W + 1;
  localparam logic [RW-1:0] FLOOR_LIM = RW'(NUM_FLOORS);

  sched_st_e state;
  logic [CNT_W-1:0] dwell_cnt;
  logic [NUM_FLOORS-1:0] pend_nxt;

  logic [FLOOR_W-1:0] up_hit;
  logic [FLOOR_W-1:0] dn_hit;
  logic up_vld;
  logic dn_vld;

  logic in_range;
  logic req_ok;
  logic req_bad;
  logic restart;
  logic serving;
  logic arrive;

  elevator_next_floor_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_pick (
    .pending   (pending),
    .car_floor (car_floor),
    .up_hit    (up_hit),
    .up_vld    (up_vld),
    .dn_hit    (dn_hit),
    .dn_vld    (dn_vld)
  );

  assign in_range = ({1'b0, req_floor} < FLOOR_LIM);
  assign req_ok   = req_valid && in_range;
  assign req_bad  = req_valid && !in_range;

  // A call for the floor the door is open at just extends the stop.
  assign restart = req_ok
                && (state == ST_DWELL)
                && (req_floor == car_floor);

  assign serving = (state == ST_SERVE_UP)
                || (state == ST_SERVE_DOWN);

  assign arrive = serving
               && car_idle
               && (car_floor == target_floor)
               && pending[target_floor];

  // Clear is applied after set so an absorbed call loses.
  always_comb begin
    pend_nxt = pending;
    if (req_ok && !restart) begin
      pend_nxt[req_floor] = 1'b1;
    end
    if (arrive) begin
      pend_nxt[target_floor] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      pending      <= '0;
      target_floor <= '0;
      dir_up       <= 1'b1;
      door_open    <= 1'b0;
      req_err      <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      pending <= pend_nxt;
      req_err <= req_bad;
      unique case (state)
        ST_IDLE: begin
          if (|pending) begin
            if (!dn_vld || (dir_up && up_vld)) begin
              state  <= ST_SERVE_UP;
              dir_up <= 1'b1;
            end else begin
              state  <= ST_SERVE_DOWN;
              dir_up <= 1'b0;
            end
          end
        end
        ST_SERVE_UP: begin
          if (arrive) begin
            state     <= ST_DWELL;
            door_open <= 1'b1;
            dwell_cnt <= DWELL_LOAD;
          end else if (up_vld) begin
            target_floor <= up_hit;
          end else if (dn_vld) begin
            state  <= ST_SERVE_DOWN;
            dir_up <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SERVE_DOWN: begin
          if (arrive) begin
            state     <= ST_DWELL;
            door_open <= 1'b1;
            dwell_cnt <= DWELL_LOAD;
          end else if (dn_vld) begin
            target_floor <= dn_hit;
          end else if (up_vld) begin
            state  <= ST_SERVE_UP;
            dir_up <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (restart) begin
            dwell_cnt <= DWELL_LOAD;
          end else if (dwell_cnt == '0) begin
            door_open <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            dwell_cnt <= dwell_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_SERVED_CNT_EN
  logic served_inc;

  assign served_inc = (state == ST_DWELL)
                   && !restart
                   && (dwell_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      served_cnt <= '0;
    end else if (served_inc
              && (served_cnt != 16'hFFFF)) begin
      served_cnt <= served_cnt + 16'd1;
    end
  end
`else
  assign served_cnt = '0;
`endif

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: vectors, directed
// scenarios with a moving-car model, and random traffic.
module tb_elevator_request_scheduler;

  localparam int NF   = 10;
  localparam int FW   = 4;
  localparam int DW   = 4;
  localparam int MOVE = 3;

  localparam int M_IDLE  = 0;
  localparam int M_UP    = 1;
  localparam int M_DN    = 2;
  localparam int M_DWELL = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic [FW-1:0] car_floor = '0;
  logic car_idle = 1'b1;
  logic [FW-1:0] target_floor;
  logic [NF-1:0] pending;
  logic dir_up;
  logic door_open;
  logic req_err;
  logic [15:0] served_cnt;

  elevator_request_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .car_floor    (car_floor),
    .car_idle     (car_idle),
    .target_floor (target_floor),
    .pending      (pending),
    .dir_up       (dir_up),
    .door_open    (door_open),
    .req_err      (req_err),
    .served_cnt   (served_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference scheduler state
  int ms;
  int mt;
  int mcnt;
  int msv;
  bit mdir;
  bit mdoor;
  bit merr;
  bit mp[NF];

  // behavioural car
  bit car_auto = 0;
  int car_f = 0;
  int mv_t = 0;

  typedef struct {
    bit rv;
    int rf;
    int cf;
    bit ci;
    int tgt;
    logic [NF-1:0] pend;
    bit door;
    bit err;
    bit dir;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic int exp_srv(input int n);
`ifdef SCHED_SERVED_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic model_reset();
    ms = M_IDLE;
    mt = 0;
    mcnt = 0;
    msv = 0;
    mdir = 1;
    mdoor = 0;
    merr = 0;
    for (int i = 0; i < NF; i++) mp[i] = 0;
  endtask

  function automatic logic [32:0] mvec();
    logic [NF-1:0] p;
    logic [15:0] s;
    for (int i = 0; i < NF; i++) p[i] = mp[i];
    s = 16'(exp_srv(msv));
    return {FW'(mt), p, mdir, mdoor, merr, s};
  endfunction

  task automatic model_step(input bit v, input int f,
                            input int cf, input bit ci);
    int up;
    int dn;
    bit any;
    bit inr;
    bit rs;
    bit arr;
    up = -1;
    dn = -1;
    any = 0;
    for (int i = NF - 1; i >= 0; i--)
      if (mp[i]) begin
        any = 1;
        if (i >= cf) up = i;
      end
    for (int i = 0; i < NF; i++)
      if (mp[i] && i <= cf) dn = i;
    inr = v && (f < NF);
    rs = inr && (ms == M_DWELL) && (f == cf);
    arr = (ms == M_UP || ms == M_DN) && ci
       && (cf == mt) && mp[mt];
    merr = v && (f >= NF);
    case (ms)
      M_IDLE:
        if (any) begin
          if (dn < 0 || (mdir && up >= 0)) begin
            ms = M_UP; mdir = 1;
          end else begin
            ms = M_DN; mdir = 0;
          end
        end
      M_UP:
        if (arr) begin
          ms = M_DWELL; mdoor = 1; mcnt = DW - 1;
        end else if (up >= 0) mt = up;
        else if (dn >= 0) begin
          ms = M_DN; mdir = 0;
        end else ms = M_IDLE;
      M_DN:
        if (arr) begin
          ms = M_DWELL; mdoor = 1; mcnt = DW - 1;
        end else if (dn >= 0) mt = dn;
        else if (up >= 0) begin
          ms = M_UP; mdir = 1;
        end else ms = M_IDLE;
      default:
        if (rs) mcnt = DW - 1;
        else if (mcnt == 0) begin
          mdoor = 0;
          ms = M_IDLE;
          if (msv < 65535) msv++;
        end else mcnt--;
    endcase
    if (inr && !rs) mp[f] = 1;
    if (arr) mp[mt] = 0;
  endtask

  task automatic cyc(input bit v, input int f);
    req_valid = v;
    req_floor = FW'(f);
    if (car_auto) begin
      car_floor = FW'(car_f);
      car_idle = (car_f == int'(target_floor));
    end
    if (reset) model_step(v, f, int'(car_floor), car_idle);
    @(posedge clk);
    #1;
    if (car_auto) begin
      int t;
      t = int'(target_floor);
      if (car_f != t) begin
        mv_t++;
        if (mv_t >= MOVE) begin
          car_f += (t > car_f) ? 1 : -1;
          mv_t = 0;
        end
      end else mv_t = 0;
    end
    check("model",
          {target_floor, pending, dir_up,
           door_open, req_err, served_cnt},
          mvec());
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    cyc(0, 0);
    reset = 1'b1;
  endtask

  task automatic wait_door(input logic lvl, input string nm);
    int n;
    n = 0;
    while (door_open !== lvl && n < 200) begin
      cyc(0, 0);
      n++;
    end
    check(nm, door_open, lvl);
  endtask

  task automatic door_len(input int want, input string nm);
    int n;
    n = 0;
    while (door_open === 1'b1 && n < 50) begin
      n++;
      cyc(0, 0);
    end
    check(nm, n, want);
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 3,  0, 1, 0, 10'h008, 0, 0, 1};
    tbl[1] = '{1, 12, 0, 1, 0, 10'h008, 0, 1, 1};
    tbl[2] = '{1, 5,  0, 1, 3, 10'h028, 0, 0, 1};
    tbl[3] = '{0, 0,  1, 0, 3, 10'h028, 0, 0, 1};
    tbl[4] = '{0, 0,  3, 1, 3, 10'h020, 1, 0, 1};
    tbl[5] = '{1, 2,  3, 1, 3, 10'h024, 1, 0, 1};
    tbl[6] = '{1, 3,  3, 1, 3, 10'h024, 1, 0, 1};
    tbl[7] = '{0, 0,  3, 1, 3, 10'h024, 1, 0, 1};

    model_reset();
    #1;
    cyc(0, 0);
    cyc(0, 0);
    reset = 1'b1;
    check("reset_state",
          {target_floor, pending, dir_up, door_open,
           req_err, served_cnt},
          {4'd0, 10'd0, 1'b1, 1'b0, 1'b0, 16'd0});

    for (int i = 0; i < 8; i++) begin
      car_floor = FW'(tbl[i].cf);
      car_idle = tbl[i].ci;
      cyc(tbl[i].rv, tbl[i].rf);
      check($sformatf("vec%0d", i),
            {target_floor, pending, door_open,
             req_err, dir_up},
            {FW'(tbl[i].tgt), tbl[i].pend, tbl[i].door,
             tbl[i].err, tbl[i].dir});
    end

    // reset in the middle of a dwell with calls 2 and 5 pending
    reset = 1'b0;
    model_reset();
    #1;
    check("t1_async",
          {target_floor, pending, door_open, dir_up},
          {4'd0, 10'd0, 1'b0, 1'b1});
    cyc(0, 0);
    reset = 1'b1;
    cyc(0, 0);
    check("t1_after",
          {target_floor, pending, door_open, dir_up},
          {4'd0, 10'd0, 1'b0, 1'b1});

    car_f = 0;
    mv_t = 0;
    car_auto = 1;

    cyc(1, 5);
    cyc(0, 0);
    cyc(0, 0);
    check("t2_target", target_floor, 5);
    wait_door(1'b1, "t2_open");
    check("t2_clear", pending[5], 1'b0);
    door_len(4, "t2_dwell_len");
    check("t2_served", served_cnt, exp_srv(1));

    cyc(1, 2);
    wait_door(1'b1, "t3_open2");
    wait_door(1'b0, "t3_close2");
    cyc(1, 7);
    n = 0;
    while (car_f != 3 && n < 100) begin
      cyc(0, 0);
      n++;
    end
    check("t3_car_at_3", car_f, 3);
    cyc(1, 4);
    cyc(0, 0);
    check("t3_retarget", target_floor, 4);
    wait_door(1'b1, "t3_open4");
    check("t3_at4", target_floor, 4);
    wait_door(1'b0, "t3_close4");
    n = 0;
    while (target_floor !== 4'd7 && n < 6) begin
      cyc(0, 0);
      n++;
    end
    check("t3_resume7", target_floor, 7);
    wait_door(1'b1, "t3_open7");
    wait_door(1'b0, "t3_close7");

    cyc(1, 5);
    wait_door(1'b1, "t4_open5");
    wait_door(1'b0, "t4_close5");
    cyc(1, 6);
    wait_door(1'b1, "t4_open6");
    cyc(1, 8);
    cyc(1, 1);
    check("t4_pend", pending, 10'h102);
    wait_door(1'b0, "t4_close6");
    wait_door(1'b1, "t4_open8");
    check("t4_first8", {target_floor, dir_up},
          {4'd8, 1'b1});
    wait_door(1'b0, "t4_close8");
    wait_door(1'b1, "t4_open1");
    check("t4_then1", {target_floor, dir_up, pending},
          {4'd1, 1'b0, 10'd0});
    wait_door(1'b0, "t4_close1");

    cyc(1, 12);
    check("t5_err", {req_err, pending}, {1'b1, 10'd0});
    cyc(0, 0);
    check("t5_err_pulse", req_err, 1'b0);
    cyc(1, 3);
    wait_door(1'b1, "t5_open3");
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 3);
    check("t5_restart", {pending[3], door_open},
          {1'b0, 1'b1});
    door_len(4, "t5_restart_len");

    check("t6_served", served_cnt, exp_srv(9));

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      else cyc($urandom_range(0, 5) == 0,
               $urandom_range(0, 11));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
